iter_divide: RTL and testbench

ITER_DIVIDE -- requirements
Module: iter_divide

---
 rtl/iter_divide_pkg.sv | 21 ++
 rtl/iter_divide.sv | 171 +++++++++++++++++
 tb/tb_iter_divide.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iter_divide_pkg.sv
// Shared types and helpers for the iterative divider.
//   div_state_e : FSM state encoding (idle, iterate, sign fix-up, result hold)
//   twos_neg    : two's-complement negate on a MaxWidth-bit word; callers
//                 widen their operand and truncate the result, which keeps
//                 the low bits exact for any width up to MaxWidth.
package iter_divide_pkg;

  localparam int unsigned MaxWidth = 64;

  typedef enum logic [1:0] {
    StIdle,
    StIter,
    StFix,
    StDone
  } div_state_e;

  function automatic logic [MaxWidth-1:0] twos_neg(input logic [MaxWidth-1:0] value);
    return ~value + 64'd1;
  endfunction

endpackage

// File: rtl/iter_divide.sv
// Iterative radix-2 restoring divider, signed or unsigned per request.
// One quotient bit is produced per cycle, so a result appears a fixed
// WIDTHN+1 edges after the accept edge, independent of operand values.
//
// Ports:
//   i_clock, i_aclr          clock, asynchronous active-high reset
//   i_valid / o_ready        request handshake (o_ready only in idle)
//   i_numer, i_denom         operands
//   i_signed                 1 = both operands two's complement
//   i_mode_ovr, i_rem_pos    per-request override of remainder-positive mode
//   o_valid / i_ready        result handshake (outputs held until consumed)
//   o_quotient, o_remain     result
//   o_div_zero               denominator was zero
//
// Widths up to iter_divide_pkg::MaxWidth are supported.
module iter_divide
  import iter_divide_pkg::*;
#(
  parameter int unsigned WIDTHN          = 32,
  parameter int unsigned WIDTHD          = 32,
  parameter bit          REM_POS_DEFAULT = 1'b1
) (
  input  logic              i_clock,
  input  logic              i_aclr,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTHN-1:0] i_numer,
  input  logic [WIDTHD-1:0] i_denom,
  input  logic              i_signed,
  input  logic              i_mode_ovr,
  input  logic              i_rem_pos,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [WIDTHN-1:0] o_quotient,
  output logic [WIDTHD-1:0] o_remain,
  output logic              o_div_zero
);

  div_state_e        state_q;
  logic [WIDTHN-1:0] cnt_q;
  // Partial remainder carries one extra bit so the trial subtraction borrow
  // can be read directly.
  logic [WIDTHD:0]   prem_q;
  // Numerator magnitude shifts out of the top while quotient bits shift in.
  logic [WIDTHN-1:0] quo_q;
  logic [WIDTHD-1:0] den_q;
  logic [WIDTHD-1:0] numer_raw_q;
  logic              sign_n_q;
  logic              sign_d_q;
  logic              signed_q;
  logic              rem_pos_q;
  logic [WIDTHN-1:0] quotient_q;
  logic [WIDTHD-1:0] remain_q;
  logic              div_zero_q;

  logic [WIDTHN-1:0] numer_mag;
  logic [WIDTHD-1:0] denom_mag;
  logic              req_rem_pos;
  logic [WIDTHD:0]   step_trial;
  logic [WIDTHD:0]   step_diff;
  logic [WIDTHD:0]   step_prem;
  logic [WIDTHN-1:0] step_quo;
  logic              quo_neg;
  logic              rem_neg;
  logic [WIDTHN-1:0] fix_quotient;
  logic [WIDTHD-1:0] fix_remain;
  logic              fix_div_zero;

  always_comb begin
    // Operand magnitudes at accept. The most-negative value maps to its own
    // bit pattern, which is the correct unsigned magnitude.
    numer_mag = i_numer;
    if (i_signed && i_numer[WIDTHN-1]) begin
      numer_mag = WIDTHN'(twos_neg(MaxWidth'(i_numer)));
    end
    denom_mag = i_denom;
    if (i_signed && i_denom[WIDTHD-1]) begin
      denom_mag = WIDTHD'(twos_neg(MaxWidth'(i_denom)));
    end
    req_rem_pos = i_mode_ovr ? i_rem_pos : REM_POS_DEFAULT;

    // Restoring step: keep the difference only if it did not borrow.
    step_trial = {prem_q[WIDTHD-1:0], quo_q[WIDTHN-1]};
    step_diff  = step_trial - {1'b0, den_q};
    if (step_diff[WIDTHD]) begin
      step_prem = step_trial;
      step_quo  = {quo_q[WIDTHN-2:0], 1'b0};
    end else begin
      step_prem = step_diff;
      step_quo  = {quo_q[WIDTHN-2:0], 1'b1};
    end

    // Sign fix-up. A zero remainder stays non-negative.
    quo_neg      = signed_q & (sign_n_q ^ sign_d_q);
    rem_neg      = signed_q & sign_n_q & (prem_q != '0);
    fix_quotient = quo_neg ? WIDTHN'(twos_neg(MaxWidth'(quo_q))) : quo_q;
    fix_remain   = rem_neg ? WIDTHD'(twos_neg(MaxWidth'(prem_q[WIDTHD-1:0])))
                           : prem_q[WIDTHD-1:0];
    if (rem_pos_q && rem_neg) begin
      fix_quotient = sign_d_q ? fix_quotient + WIDTHN'(1) : fix_quotient - WIDTHN'(1);
      fix_remain   = fix_remain + den_q;
    end
    fix_div_zero = (den_q == '0);
    if (fix_div_zero) begin
      fix_quotient = '1;
      fix_remain   = numer_raw_q;
    end
  end

  always_ff @(posedge i_clock or posedge i_aclr) begin
    if (i_aclr) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      prem_q      <= '0;
      quo_q       <= '0;
      den_q       <= '0;
      numer_raw_q <= '0;
      sign_n_q    <= 1'b0;
      sign_d_q    <= 1'b0;
      signed_q    <= 1'b0;
      rem_pos_q   <= 1'b0;
      quotient_q  <= '0;
      remain_q    <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (i_valid) begin
            prem_q      <= '0;
            quo_q       <= numer_mag;
            den_q       <= denom_mag;
            numer_raw_q <= WIDTHD'(i_numer);
            sign_n_q    <= i_numer[WIDTHN-1];
            sign_d_q    <= i_denom[WIDTHD-1];
            signed_q    <= i_signed;
            rem_pos_q   <= req_rem_pos;
            cnt_q       <= WIDTHN'(WIDTHN - 1);
            state_q     <= StIter;
          end
        end
        StIter: begin
          prem_q <= step_prem;
          quo_q  <= step_quo;
          cnt_q  <= cnt_q - WIDTHN'(1);
          if (cnt_q == '0) begin
            state_q <= StFix;
          end
        end
        StFix: begin
          quotient_q <= fix_quotient;
          remain_q   <= fix_remain;
          div_zero_q <= fix_div_zero;
          state_q    <= StDone;
        end
        StDone: begin
          if (i_ready) begin
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_ready    = (state_q == StIdle);
  assign o_valid    = (state_q == StDone);
  assign o_quotient = quotient_q;
  assign o_remain   = remain_q;
  assign o_div_zero = div_zero_q;

endmodule

// File: tb/tb_iter_divide.sv
// Self-checking bench for iter_divide at WIDTHN=WIDTHD=8, REM_POS_DEFAULT=1.
// Expected results are pushed to a scoreboard queue when a request is driven
// and popped when the divider presents its result.
module tb_iter_divide;

  typedef struct packed {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
  } exp_t;

  logic       i_clock = 1'b0;
  logic       i_aclr  = 1'b1;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic [7:0] i_numer = '0;
  logic [7:0] i_denom = '0;
  logic       i_signed   = 1'b0;
  logic       i_mode_ovr = 1'b0;
  logic       i_rem_pos  = 1'b0;
  logic       o_valid;
  logic       i_ready = 1'b0;
  logic [7:0] o_quotient;
  logic [7:0] o_remain;
  logic       o_div_zero;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];

  iter_divide #(
    .WIDTHN         (8),
    .WIDTHD         (8),
    .REM_POS_DEFAULT(1'b1)
  ) dut (
    .i_clock   (i_clock),
    .i_aclr    (i_aclr),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_numer   (i_numer),
    .i_denom   (i_denom),
    .i_signed  (i_signed),
    .i_mode_ovr(i_mode_ovr),
    .i_rem_pos (i_rem_pos),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_quotient(o_quotient),
    .o_remain  (o_remain),
    .o_div_zero(o_div_zero)
  );

  always #5 i_clock = ~i_clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: truncating division, remainder follows the dividend, then the
  // optional shift to a non-negative remainder.
  function automatic exp_t model(input logic [7:0] n, input logic [7:0] d,
                                 input logic sg, input logic ovr, input logic rp);
    exp_t e;
    int   ni, di, qi, ri;
    logic mode;
    mode = ovr ? rp : 1'b1;
    if (d == 8'h00) begin
      e.q  = 8'hFF;
      e.r  = n;
      e.dz = 1'b1;
      return e;
    end
    if (sg) begin
      ni = int'($signed(n));
      di = int'($signed(d));
    end else begin
      ni = int'({24'd0, n});
      di = int'({24'd0, d});
    end
    qi = ni / di;
    ri = ni % di;
    if (sg && mode && ri < 0) begin
      qi = (di < 0) ? qi + 1 : qi - 1;
      ri = ri + ((di < 0) ? -di : di);
    end
    e.q  = qi[7:0];
    e.r  = ri[7:0];
    e.dz = 1'b0;
    return e;
  endfunction

  // Drive one request and return after its accept edge.
  task automatic start_op(input logic [7:0] n, input logic [7:0] d, input logic sg,
                          input logic ovr, input logic rp, output bit to);
    int waited = 0;
    while (o_ready !== 1'b1 && waited < 50) begin
      @(posedge i_clock); #1;
      waited++;
    end
    to         = (waited >= 50);
    i_valid    = 1'b1;
    i_numer    = n;
    i_denom    = d;
    i_signed   = sg;
    i_mode_ovr = ovr;
    i_rem_pos  = rp;
    @(posedge i_clock); #1;
    i_valid    = 1'b0;
  endtask

  // Count edges from the accept edge until o_valid is seen.
  task automatic wait_valid(output int lat, output bit to);
    lat = 0;
    while (o_valid !== 1'b1 && lat < 40) begin
      @(posedge i_clock); #1;
      lat++;
    end
    to = (o_valid !== 1'b1);
  endtask

  task automatic consume();
    i_ready = 1'b1;
    @(posedge i_clock); #1;
    i_ready = 1'b0;
  endtask

  task automatic test_reset();
    i_aclr = 1'b1;
    repeat (2) @(posedge i_clock);
    #1;
    total++;
    if ({o_ready, o_valid, o_quotient, o_remain, o_div_zero} !== {1'b1, 1'b0, 8'h00, 8'h00, 1'b0}) begin
      bad++;
      $display("FAIL reset_state: got rdy=%b vld=%b q=%h r=%h dz=%b want rdy=1 vld=0 q=00 r=00 dz=0",
               o_ready, o_valid, o_quotient, o_remain, o_div_zero);
    end
    i_aclr = 1'b0;
    @(posedge i_clock); #1;
  endtask

  // Run a list of directed requests whose expectations are pushed as constants.
  task automatic run_directed(input string name, input logic [7:0] n, input logic [7:0] d,
                              input logic sg, input logic ovr, input logic rp,
                              input exp_t want);
    bit   to_a, to_v;
    int   lat;
    exp_t e;
    sb.push_back(want);
    start_op(n, d, sg, ovr, rp, to_a);
    wait_valid(lat, to_v);
    total++;
    if (to_a || to_v) begin
      bad++;
      $display("FAIL %s_timeout: got no handshake within bound, want o_valid", name);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    if ({o_quotient, o_remain, o_div_zero} !== {e.q, e.r, e.dz}) begin
      bad++;
      $display("FAIL %s: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
               name, o_quotient, o_remain, o_div_zero, e.q, e.r, e.dz);
    end
    total++;
    if (lat != 9) begin
      bad++;
      $display("FAIL %s_latency: got %0d edges want 9", name, lat);
    end
    consume();
  endtask

  task automatic test_unsigned();
    run_directed("u200_7", 8'd200, 8'd7, 1'b0, 1'b0, 1'b0, exp_t'{8'd28, 8'd4, 1'b0});
    run_directed("u255_16", 8'd255, 8'd16, 1'b0, 1'b1, 1'b1, exp_t'{8'd15, 8'd15, 1'b0});
  endtask

  task automatic test_signed();
    run_directed("s_m7_2_trunc", 8'hF9, 8'h02, 1'b1, 1'b1, 1'b0, exp_t'{8'hFD, 8'hFF, 1'b0});
    run_directed("s_m7_2_rempos", 8'hF9, 8'h02, 1'b1, 1'b0, 1'b0, exp_t'{8'hFC, 8'h01, 1'b0});
    run_directed("s_7_m2", 8'h07, 8'hFE, 1'b1, 1'b0, 1'b0, exp_t'{8'hFD, 8'h01, 1'b0});
    run_directed("s_m8_4_zero_rem", 8'hF8, 8'h04, 1'b1, 1'b0, 1'b0, exp_t'{8'hFE, 8'h00, 1'b0});
  endtask

  task automatic test_boundary();
    run_directed("div0_u", 8'h55, 8'h00, 1'b0, 1'b0, 1'b0, exp_t'{8'hFF, 8'h55, 1'b1});
    run_directed("div0_s", 8'h80, 8'h00, 1'b1, 1'b0, 1'b0, exp_t'{8'hFF, 8'h80, 1'b1});
    run_directed("minneg_m1", 8'h80, 8'hFF, 1'b1, 1'b0, 1'b0, exp_t'{8'h80, 8'h00, 1'b0});
  endtask

  task automatic test_back_to_back();
    bit         to_a, to_v;
    int         lat, unstable;
    exp_t       e;
    logic [16:0] held;
    sb.push_back(exp_t'{8'd11, 8'd1, 1'b0});
    start_op(8'd100, 8'd9, 1'b0, 1'b0, 1'b0, to_a);
    wait_valid(lat, to_v);
    total++;
    if (to_a || to_v) begin
      bad++;
      $display("FAIL bp_timeout: got no o_valid within bound, want o_valid");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "no result");
    end
    e = sb.pop_front();
    if ({o_quotient, o_remain, o_div_zero} !== {e.q, e.r, e.dz}) begin
      bad++;
      $display("FAIL bp_result: got q=%h r=%h want q=%h r=%h", o_quotient, o_remain, e.q, e.r);
    end
    held     = {o_quotient, o_remain, o_div_zero};
    unstable = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_clock); #1;
      if ({o_quotient, o_remain, o_div_zero} !== held || o_valid !== 1'b1 || o_ready !== 1'b0)
        unstable++;
    end
    total++;
    if (unstable != 0) begin
      bad++;
      $display("FAIL bp_hold: got %0d unstable cycles want 0", unstable);
    end
    consume();
    total++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", o_ready, o_valid);
    end
    run_directed("b2b_m128_3", 8'h80, 8'h03, 1'b1, 1'b0, 1'b0, exp_t'{8'hD5, 8'h01, 1'b0});
  endtask

  task automatic test_reset_mid();
    bit to_a;
    int seen;
    start_op(8'd200, 8'd7, 1'b0, 1'b0, 1'b0, to_a);
    repeat (2) @(posedge i_clock);
    #1;
    i_aclr = 1'b1;
    #1;
    total++;
    if (to_a || o_valid !== 1'b0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_mid: got vld=%b rdy=%b want vld=0 rdy=1", o_valid, o_ready);
    end
    @(posedge i_clock); #1;
    i_aclr = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge i_clock); #1;
      if (o_valid !== 1'b0) seen++;
    end
    total++;
    if (seen != 0 || o_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_no_result: got %0d valid cycles rdy=%b want 0 and rdy=1", seen, o_ready);
    end
  endtask

  task automatic test_random();
    bit         to_a, to_v;
    int         lat;
    exp_t       e;
    logic [7:0] n, d;
    logic       sg, ovr, rp;
    for (int k = 0; k < 3000; k++) begin
      n   = 8'($urandom);
      d   = 8'($urandom);
      sg  = 1'($urandom_range(0, 1));
      ovr = 1'($urandom_range(0, 1));
      rp  = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 15))
        0: d = 8'h00;
        1: d = 8'hFF;
        2: n = 8'h80;
        3: d = 8'h80;
        default: ;
      endcase
      sb.push_back(model(n, d, sg, ovr, rp));
      repeat ($urandom_range(0, 1)) @(posedge i_clock);
      #1;
      start_op(n, d, sg, ovr, rp, to_a);
      wait_valid(lat, to_v);
      total++;
      if (to_a || to_v) begin
        bad++;
        $display("FAIL rand_timeout[%0d]: got no handshake within bound, want o_valid", k);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "no result");
      end
      e = sb.pop_front();
      if ({o_quotient, o_remain, o_div_zero} !== {e.q, e.r, e.dz}) begin
        bad++;
        $display("FAIL rand[%0d] n=%h d=%h s=%b ovr=%b rp=%b: got q=%h r=%h dz=%b want q=%h r=%h dz=%b",
                 k, n, d, sg, ovr, rp, o_quotient, o_remain, o_div_zero, e.q, e.r, e.dz);
      end
      total++;
      if (lat != 9) begin
        bad++;
        $display("FAIL rand_latency[%0d]: got %0d edges want 9", k, lat);
      end
      repeat ($urandom_range(0, 3)) @(posedge i_clock);
      #1;
      consume();
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_boundary();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
